// File: rtl/logic_gates_using_mux.sv
// Bitwise logic unit whose entire gate network is built from 2:1 mux cells.
// Each bit has its own mux slice; all seven results are registered.

module mux2_cell (
   input  logic sel,
   input  logic i0,
   input  logic i1,
   output logic y
);
   assign y = sel ? i1 : i0;
endmodule

module logic_gates_using_mux #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] AND_Y,
   output logic [WIDTH-1:0] OR_Y,
   output logic [WIDTH-1:0] XOR_Y,
   output logic [WIDTH-1:0] NAND_Y,
   output logic [WIDTH-1:0] NOR_Y,
   output logic [WIDTH-1:0] XNOR_Y,
   output logic [WIDTH-1:0] NOT_A
);

   logic [WIDTH-1:0] not_b;
   logic [WIDTH-1:0] and_d;
   logic [WIDTH-1:0] or_d;
   logic [WIDTH-1:0] xor_d;
   logic [WIDTH-1:0] nand_d;
   logic [WIDTH-1:0] nor_d;
   logic [WIDTH-1:0] xnor_d;
   logic [WIDTH-1:0] nota_d;

   // A[i] selects for every two-input gate; ~B[i] comes from its own mux on B[i].
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      mux2_cell u_notb (.sel(B[i]), .i0(1'b1),     .i1(1'b0),     .y(not_b[i]));
      mux2_cell u_and  (.sel(A[i]), .i0(1'b0),     .i1(B[i]),     .y(and_d[i]));
      mux2_cell u_or   (.sel(A[i]), .i0(B[i]),     .i1(1'b1),     .y(or_d[i]));
      mux2_cell u_xor  (.sel(A[i]), .i0(B[i]),     .i1(not_b[i]), .y(xor_d[i]));
      mux2_cell u_nand (.sel(A[i]), .i0(1'b1),     .i1(not_b[i]), .y(nand_d[i]));
      mux2_cell u_nor  (.sel(A[i]), .i0(not_b[i]), .i1(1'b0),     .y(nor_d[i]));
      mux2_cell u_xnor (.sel(A[i]), .i0(not_b[i]), .i1(B[i]),     .y(xnor_d[i]));
      mux2_cell u_nota (.sel(A[i]), .i0(1'b1),     .i1(1'b0),     .y(nota_d[i]));
   end

   // Reset clears every output, including the ones whose logical value at A=B=0 is 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         AND_Y  <= '0;
         OR_Y   <= '0;
         XOR_Y  <= '0;
         NAND_Y <= '0;
         NOR_Y  <= '0;
         XNOR_Y <= '0;
         NOT_A  <= '0;
      end else begin
         AND_Y  <= and_d;
         OR_Y   <= or_d;
         XOR_Y  <= xor_d;
         NAND_Y <= nand_d;
         NOR_Y  <= nor_d;
         XNOR_Y <= xnor_d;
         NOT_A  <= nota_d;
      end
   end

endmodule

// File: tb/tb_logic_gates_using_mux.sv
// Bench for logic_gates_using_mux: a 1-bit and a 4-bit instance on a shared clock/reset,
// checked against a reference model of the registered logic results.

module tb_logic_gates_using_mux;

   logic       clk;
   logic       rst_n;
   logic [0:0] a1, b1;
   logic [3:0] a4, b4;
   logic [0:0] and1, or1, xor1, nand1, nor1, xnor1, nota1;
   logic [3:0] and4, or4, xor4, nand4, nor4, xnor4, nota4;

   int compared   = 0;
   int mismatched = 0;

   // Reference model state: operands captured at the last clocked edge, or cleared by reset.
   logic [0:0] h_a1, h_b1;
   logic [3:0] h_a4, h_b4;
   bit         h_zero;

   logic [3:0] ta, tb_v;

   logic_gates_using_mux #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .A(a1), .B(b1),
      .AND_Y(and1), .OR_Y(or1), .XOR_Y(xor1), .NAND_Y(nand1),
      .NOR_Y(nor1), .XNOR_Y(xnor1), .NOT_A(nota1)
   );

   logic_gates_using_mux #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .A(a4), .B(b4),
      .AND_Y(and4), .OR_Y(or4), .XOR_Y(xor4), .NAND_Y(nand4),
      .NOR_Y(nor4), .XNOR_Y(xnor4), .NOT_A(nota4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Compare every output of both instances against the model.
   task automatic check_all(input string tag);
      logic [3:0] ea, eb;
      logic       sa, sb;
      ea = h_a4; eb = h_b4; sa = h_a1[0]; sb = h_b1[0];
      if (h_zero) begin
         check({tag, " and4"},  and4,  4'b0);
         check({tag, " or4"},   or4,   4'b0);
         check({tag, " xor4"},  xor4,  4'b0);
         check({tag, " nand4"}, nand4, 4'b0);
         check({tag, " nor4"},  nor4,  4'b0);
         check({tag, " xnor4"}, xnor4, 4'b0);
         check({tag, " nota4"}, nota4, 4'b0);
         check({tag, " and1"},  {3'b0, and1},  4'b0);
         check({tag, " or1"},   {3'b0, or1},   4'b0);
         check({tag, " xor1"},  {3'b0, xor1},  4'b0);
         check({tag, " nand1"}, {3'b0, nand1}, 4'b0);
         check({tag, " nor1"},  {3'b0, nor1},  4'b0);
         check({tag, " xnor1"}, {3'b0, xnor1}, 4'b0);
         check({tag, " nota1"}, {3'b0, nota1}, 4'b0);
      end else begin
         check({tag, " and4"},  and4,  ea & eb);
         check({tag, " or4"},   or4,   ea | eb);
         check({tag, " xor4"},  xor4,  ea ^ eb);
         check({tag, " nand4"}, nand4, ~(ea & eb));
         check({tag, " nor4"},  nor4,  ~(ea | eb));
         check({tag, " xnor4"}, xnor4, ~(ea ^ eb));
         check({tag, " nota4"}, nota4, ~ea);
         check({tag, " and1"},  {3'b0, and1},  {3'b0, sa & sb});
         check({tag, " or1"},   {3'b0, or1},   {3'b0, sa | sb});
         check({tag, " xor1"},  {3'b0, xor1},  {3'b0, sa ^ sb});
         check({tag, " nand1"}, {3'b0, nand1}, {3'b0, ~(sa & sb)});
         check({tag, " nor1"},  {3'b0, nor1},  {3'b0, ~(sa | sb)});
         check({tag, " xnor1"}, {3'b0, xnor1}, {3'b0, ~(sa ^ sb)});
         check({tag, " nota1"}, {3'b0, nota1}, {3'b0, ~sa});
      end
   endtask

   // One rising edge, then settle on the falling edge where outputs are sampled.
   task automatic step();
      @(posedge clk);
      if (rst_n) begin
         h_a1 = a1; h_b1 = b1; h_a4 = a4; h_b4 = b4; h_zero = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic [3:0] va4, input logic [3:0] vb4,
                        input logic va1, input logic vb1);
      a4 = va4; b4 = vb4; a1 = va1; b1 = vb1;
   endtask

   initial begin
      h_zero = 1'b1;
      h_a1 = '0; h_b1 = '0; h_a4 = '0; h_b4 = '0;
      rst_n = 1'b0;
      drive(4'hF, 4'hF, 1'b1, 1'b1);

      // Reset held with ones on the inputs and the clock running.
      repeat (3) step();
      check_all("reset");

      rst_n = 1'b1;
      step();
      check_all("first_capture");
      check("first_capture and1 direct", {3'b0, and1}, 4'b0001);
      check("first_capture nand1 direct", {3'b0, nand1}, 4'b0000);

      // 1-bit truth table, one vector per cycle, with the 4-bit instance exercising 1100/1010.
      drive(4'b1100, 4'b1010, 1'b0, 1'b0); step(); check_all("tt_00");
      check("tt_00 nand1 direct", {3'b0, nand1}, 4'b0001);
      check("w4 and direct",  and4,  4'b1000);
      check("w4 or direct",   or4,   4'b1110);
      check("w4 xor direct",  xor4,  4'b0110);
      check("w4 nand direct", nand4, 4'b0111);
      check("w4 nor direct",  nor4,  4'b0001);
      check("w4 xnor direct", xnor4, 4'b1001);
      check("w4 nota direct", nota4, 4'b0011);
      drive(4'b0101, 4'b0011, 1'b0, 1'b1); step(); check_all("tt_01");
      drive(4'b1111, 4'b0000, 1'b1, 1'b0); step(); check_all("tt_10");
      drive(4'b0000, 4'b1111, 1'b1, 1'b1); step(); check_all("tt_11");

      // Latency: input change between edges must not reach the outputs early.
      drive(4'b1001, 4'b0110, 1'b0, 1'b1);
      #2;
      check_all("latency_hold");
      step();
      check_all("latency_update");

      // Async reset mid-stream while outputs hold A=0 B=0 results.
      drive(4'b0000, 4'b0000, 1'b0, 1'b0);
      step();
      check_all("hold_00");
      #2;
      rst_n = 1'b0;
      h_zero = 1'b1;
      #1;
      check_all("async_reset");
      drive(4'b1010, 4'b0110, 1'b1, 1'b0);
      step();
      check_all("reset_held_discard");
      rst_n = 1'b1;
      step();
      check_all("post_reset_capture");

      // Randomized vectors.
      for (int i = 0; i < 40; i++) begin
         ta   = 4'($urandom_range(0, 15));
         tb_v = 4'($urandom_range(0, 15));
         drive(ta, tb_v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         step();
         check_all("random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/logic_gates_using_mux.md
Name: logic_gates_using_mux

Overview:
- Universal-gate demonstrator: builds AND, OR, XOR, NAND, NOR, XNOR and NOT purely from 2:1 multiplexer cells.
- Results are registered so the block drops into a synchronous datapath as a bitwise logic unit.
- Operands are WIDTH-bit vectors; each bit is processed independently by its own mux slice.

Parameters:
- WIDTH, 1, bit width of operands A, B and of every result output.

Ports:
- clk  input  1  system clock; all outputs update on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- A  input  WIDTH  operand A; also the mux select for every two-input gate.
- B  input  WIDTH  operand B; mux data source.
- AND_Y  output  WIDTH  registered A & B.
- OR_Y  output  WIDTH  registered A | B.
- XOR_Y  output  WIDTH  registered A ^ B.
- NAND_Y  output  WIDTH  registered ~(A & B).
- NOR_Y  output  WIDTH  registered ~(A | B).
- XNOR_Y  output  WIDTH  registered ~(A ^ B).
- NOT_A  output  WIDTH  registered ~A.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Primitive cell: 2:1 mux, Y = S ? I1 : I0. It is the only logic element permitted in the gate network; constants 0/1 may drive data inputs.
- Per-bit mux mapping, select = A[i] unless stated:
  - NOTB: sel B[i], I0=1, I1=0.
  - AND: I0=0, I1=B.
  - OR: I0=B, I1=1.
  - XOR: I0=B, I1=NOTB.
  - NAND: I0=1, I1=NOTB.
  - NOR: I0=NOTB, I1=0.
  - XNOR: I0=NOTB, I1=B.
  - NOT_A: I0=1, I1=0.
- Output registers: all seven WIDTH-bit outputs are flops capturing mux results on rising clk.
- Latency: exactly 1 cycle from A/B sampled at edge N to outputs valid after edge N.
- No enable or handshake: every edge captures.
- Reset:
  - rst_n low clears all outputs to 0 immediately, independent of clk. This includes NAND_Y, NOR_Y, XNOR_Y and NOT_A, which read 0 during reset even though their logical value for A=B=0 is 1.
  - First capture occurs on the first rising edge after rst_n deasserts.
  - Reset asserted mid-operation clears outputs at once; pending inputs are discarded.
- Bits are fully independent; no carry or cross-bit interaction for any WIDTH.
- X on A or B propagates as X to the affected outputs; no special handling.

Test Plan:
- Reset: rst_n=0 with A=1, B=1, clk toggling -> all outputs 0; release rst_n, next edge -> AND_Y=1, OR_Y=1, XOR_Y=0, NAND_Y=0, NOR_Y=0, XNOR_Y=1, NOT_A=0.
- Truth table, WIDTH=1, one vector per cycle:
  - A=0 B=0 -> AND 0, OR 0, XOR 0, NAND 1, NOR 1, XNOR 1, NOT_A 1.
  - A=0 B=1 -> 0,1,1,1,0,0,1.
  - A=1 B=0 -> 0,1,1,1,0,0,0.
  - A=1 B=1 -> 1,1,0,0,0,1,0.
- Latency: change A/B between edges -> outputs unchanged until the next rising edge, then reflect the new values.
- Async reset mid-stream: assert rst_n low between edges while outputs hold A=0 B=0 results -> all outputs 0 before the next edge.
- WIDTH=4: A=4'b1100, B=4'b1010 -> AND 1000, OR 1110, XOR 0110, NAND 0111, NOR 0001, XNOR 1001, NOT_A 0011.
- Structural check: gate network contains only 2:1 mux instances; no behavioural &, |, ^ or ~ operators in the gate path.
